// File: rtl/fetch_buffer.sv
// Instruction fetch queue between fetch and decode: a DEPTH-entry circular buffer of {pc, pc+4, instr}.
// Optional same-cycle bypass of an empty queue is enabled by defining FETCH_BUF_BYPASS_EN.
module fetch_buffer #(
    parameter int              WIDTH = 32,
    parameter int              DEPTH = 4,
    parameter logic [WIDTH-1:0] NOP  = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_pc,
    input  logic [WIDTH-1:0]           in_pc4,
    input  logic [WIDTH-1:0]           in_instr,
    input  logic                       flush,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           PCD,
    output logic [WIDTH-1:0]           PCPlus4D,
    output logic [WIDTH-1:0]           InstrD,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] pc4_mem   [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;

    logic not_empty;
    logic bypass;
    logic push;
    logic pop;

    assign not_empty = (count_reg != '0);
    assign in_ready  = (count_reg != FULL);

`ifdef FETCH_BUF_BYPASS_EN
    assign bypass = ~not_empty & in_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry taken by decode in the same cycle never touches the array.
    assign push      = in_valid & in_ready & ~(bypass & out_ready);
    assign pop       = not_empty & out_ready;
    assign out_valid = not_empty | bypass;
    assign count     = count_reg;

    always_comb begin
        PCD      = '0;
        PCPlus4D = '0;
        InstrD   = NOP;
        if (bypass) begin
            PCD      = in_pc;
            PCPlus4D = in_pc4;
            InstrD   = in_instr;
        end else if (not_empty) begin
            PCD      = pc_mem[rd_ptr_reg];
            PCPlus4D = pc4_mem[rd_ptr_reg];
            InstrD   = instr_mem[rd_ptr_reg];
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Entries carry a reset value so a freshly reset queue never exposes stale data.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pc_mem[gi]    <= '0;
                    pc4_mem[gi]   <= '0;
                    instr_mem[gi] <= NOP;
                end else if (push && !flush && wr_ptr_reg == AW'(gi)) begin
                    pc_mem[gi]    <= in_pc;
                    pc4_mem[gi]   <= in_pc4;
                    instr_mem[gi] <= in_instr;
                end
            end
        end
    endgenerate
endmodule
